lift_request_scheduler: RTL and testbench
=========================================

// Module: lift_request_scheduler
// PURPOSE
//  Upstream of lift_controller. Debounces the three raw car/hall call buttons and latches
//  them as pending requests. Issues one target floor at a time to lift_controller as a held
//  one-hot level on ground/first/second. Retires a request once the car reports arrival
//  (curr one-hot == target and idle=1), then holds a door-dwell period.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive stable-high cycles (after sync) to accept a press
//  DOOR_CYCLES      8     dwell cycles in ARRIVED before the next request is dispatched
//  DRIVE_TIMEOUT    1024  max cycles in DRIVE without arrival before FAULT
// PORTS
//  clk         in   1  system clock, rising edge
//  reset_n     in   1  asynchronous active-low reset
//  btn_ground  in   1  raw button, floor 0 (asynchronous, bouncy)
//  btn_first   in   1  raw button, floor 1
//  btn_second  in   1  raw button, floor 2
//  curr1       in   1  car at floor 0 (from lift_controller)
//  curr2       in   1  car at floor 1
//  curr3       in   1  car at floor 2
//  idle        in   1  lift_controller stopped at target
//  ground      out  1  target floor 0 (to lift_controller), one-hot with first/second
//  first       out  1  target floor 1
//  second      out  1  target floor 2
//  pending     out  3  latched requests, bit i = floor i
//  busy        out  1  state != S_IDLE
//  fault       out  1  drive timeout occurred; sticky until reset
// BEHAVIOUR
//  Reset (async assert, sync deassert): pending=0, ground/first/second=0, busy=0, fault=0,
//   dir=UP, state=S_IDLE, all debounce and dwell/timeout counters=0.
//  Debounce, per button: 2-flop synchroniser, then a counter. Debounced level goes 1 after
//   DEBOUNCE_CYCLES consecutive synced highs and 0 on the first synced low.
//   Rising edge of debounced level sets pending[i].
//   Latency: raw press to pending set = 2 + DEBOUNCE_CYCLES cycles.
//  curr valid = {curr3,curr2,curr1} exactly one-hot. Invalid curr stalls S_IDLE and S_SELECT
//   (no transition, no pending change).
//  FSM:
//   S_IDLE: when pending!=0 and curr valid -> S_SELECT.
//   S_SELECT, one cycle, registers tgt:
//    - If pending[curr floor] is set, tgt=curr and go to S_ARRIVED.
//    - Otherwise tgt = nearest pending floor in dir.
//    - If none exists in dir, toggle dir and take the nearest in the new direction.
//    - Then go to S_DRIVE.
//   S_DRIVE: outputs ground/first/second = tgt one-hot, held stable for the whole state.
//    - Target visible 2 cycles after pending leaves 0 from S_IDLE.
//    - idle=1 and curr==tgt -> S_ARRIVED.
//    - Timeout counter reaches DRIVE_TIMEOUT-1 -> S_FAULT.
//   S_ARRIVED: clear pending[tgt] on entry and drop target outputs to 0 (lift_controller
//    keeps its latched target). Count DOOR_CYCLES, then -> S_IDLE.
//   S_FAULT: target outputs 0, fault=1, pending keeps accepting presses. Exit only by reset.
//  Simultaneous events:
//   - A press on tgt floor in the same cycle as its clear, or at any time during S_ARRIVED,
//     is dropped (door open).
//   - Presses on other floors set pending in any state.
//   - Multiple new presses in one cycle all latch.
//   - pending changes during S_DRIVE never retarget; the new request is picked at the next
//     S_SELECT.
//  Reset mid-DRIVE: outputs go 0 immediately and all pending requests are lost.
//  Counters are saturating-free: each resets on state entry. Width =
//   $clog2(param+1) per counter.
// STRUCTURE
//  lift_pkg holds:
//   - state enum S_IDLE/S_SELECT/S_DRIVE/S_ARRIVED/S_FAULT
//   - floor one-hot constants FLOOR_G=3'b001, FLOOR_1=3'b010, FLOOR_2=3'b100
//   - DIR_UP/DIR_DOWN
//  Sub-module lift_debounce (sync + counter + rise pulse, parameter DEBOUNCE_CYCLES),
//   instantiated three times. FSM, selection logic and pending register are in this module.
// TESTING
//  1. Car at floor 0 idle; btn_second held high 10 cycles.
//     -> pending=3'b100 at cycle 6; second=1 two cycles later; busy=1.
//  2. btn_first bounces 1,0,1,0 on single cycles.
//     -> pending stays 0; then 4 stable cycles -> pending[1]=1.
//  3. Car at floor 1, dir=UP, pending=3'b101 set together.
//     -> second=1 first; after curr3=1,idle=1 -> pending=3'b001, DOOR_CYCLES=8 dwell;
//        then ground=1 with dir=DOWN.
//  4. Press floor car is sitting at (curr2=1, idle=1).
//     -> S_SELECT goes directly to S_ARRIVED; pending[1] cleared; no target pulse issued.
//  5. In S_DRIVE to floor 2, never report arrival.
//     -> fault=1 after DRIVE_TIMEOUT cycles; outputs 0; a later press sets pending only.
//  6. Assert reset_n=0 mid-S_DRIVE.
//     -> target outputs, pending, busy, fault all 0 asynchronously; dir=UP after release.

Source files
------------

// File: rtl/lift_request_scheduler_pkg.sv
// Shared types and helpers for the lift request scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package lift_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_DRIVE   = 3'd2,
        S_ARRIVED = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [2:0] FLOOR_G = 3'b001;
    localparam logic [2:0] FLOOR_1 = 3'b010;
    localparam logic [2:0] FLOOR_2 = 3'b100;

    // True when the car position vector names exactly one floor.
    function automatic logic floor_valid(input logic [2:0] pos);
        return (pos == FLOOR_G) || (pos == FLOOR_1) || (pos == FLOOR_2);
    endfunction

    // Nearest pending floor strictly beyond pos in direction d, one-hot; 0 if none.
    function automatic logic [2:0] nearest_pending(input logic [2:0] pend,
                                                   input logic [2:0] pos,
                                                   input dir_t       d);
        logic [2:0] pick;
        pick = 3'b000;
        if (d == DIR_UP) begin
            if (pos == FLOOR_G) begin
                if (pend[1])      pick = FLOOR_1;
                else if (pend[2]) pick = FLOOR_2;
            end else if (pos == FLOOR_1) begin
                if (pend[2])      pick = FLOOR_2;
            end
        end else begin
            if (pos == FLOOR_2) begin
                if (pend[1])      pick = FLOOR_1;
                else if (pend[0]) pick = FLOOR_G;
            end else if (pos == FLOOR_1) begin
                if (pend[0])      pick = FLOOR_G;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lift_request_scheduler_if.sv
// Button, car-position and target signals between the lift environment and the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; targets are held levels, buttons and position are free-running inputs.
interface lift_request_scheduler_if;
    logic       btn_ground;
    logic       btn_first;
    logic       btn_second;
    logic       curr1;
    logic       curr2;
    logic       curr3;
    logic       idle;
    logic       ground;
    logic       first;
    logic       second;
    logic [2:0] pending;
    logic       busy;
    logic       fault;

    // Environment side: buttons and lift_controller status in, targets out.
    modport master (
        output btn_ground, btn_first, btn_second, curr1, curr2, curr3, idle,
        input  ground, first, second, pending, busy, fault
    );

    // Scheduler side.
    modport slave (
        input  btn_ground, btn_first, btn_second, curr1, curr2, curr3, idle,
        output ground, first, second, pending, busy, fault
    );
endinterface

// File: rtl/lift_request_scheduler_debounce.sv
// Synchronises one raw button and emits a single-cycle pulse when a press is accepted.
// Latency: pulse is seen in the cycle before the edge that completes 2 sync + DEBOUNCE_CYCLES highs.
// Backpressure: none; the pulse is fire-and-forget.
module lift_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive synced highs; the first low clears, the count parks at its max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!sync2) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The debounced level turns on when cnt reaches max; pulse on the sample that gets it there.
    assign rise = sync2 && (cnt == CNT_LAST);

endmodule

// File: rtl/lift_request_scheduler.sv
// Debounces call buttons, latches pending requests and dispatches one target floor at a time.
// Latency: press to pending 2+DEBOUNCE_CYCLES cycles; pending to target output 2 cycles.
// Backpressure: none; targets are held while driving, requests on other floors always latch.
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DOOR_CYCLES     = 8,
    parameter int DRIVE_TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    lift_request_scheduler_if.slave bus
);
    localparam int               DW        = $clog2(DOOR_CYCLES + 1);
    localparam int               TW        = $clog2(DRIVE_TIMEOUT + 1);
    localparam logic [DW-1:0]    DOOR_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0]    TO_LAST   = TW'(DRIVE_TIMEOUT - 1);

    logic          rst_meta;
    logic          rst_n;
    logic [2:0]    rise_vec;
    logic [2:0]    curr_vec;
    logic          curr_ok;

    state_t        state, state_nxt;
    dir_t          dir, dir_nxt;
    logic [2:0]    tgt, tgt_nxt;
    logic [2:0]    pending, pending_nxt;
    logic [2:0]    clr_mask;
    logic [2:0]    drop_mask;
    logic [2:0]    sel_fwd;
    logic [2:0]    sel_rev;
    logic [DW-1:0] dwell_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    tgt_out;

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    lift_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_g (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_ground), .rise(rise_vec[0]));
    lift_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_1 (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_first),  .rise(rise_vec[1]));
    lift_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_2 (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_second), .rise(rise_vec[2]));

    assign curr_vec = {bus.curr3, bus.curr2, bus.curr1};
    assign curr_ok  = floor_valid(curr_vec);
    assign sel_fwd  = nearest_pending(pending, curr_vec, dir);
    assign sel_rev  = nearest_pending(pending, curr_vec, (dir == DIR_UP) ? DIR_DOWN : DIR_UP);

    // State, direction, target and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            dir     <= DIR_UP;
            tgt     <= 3'b000;
            pending <= 3'b000;
        end else begin
            state   <= state_nxt;
            dir     <= dir_nxt;
            tgt     <= tgt_nxt;
            pending <= pending_nxt;
        end
    end

    // Next-state, target selection and pending set/clear.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        tgt_nxt   = tgt;
        clr_mask  = 3'b000;
        drop_mask = 3'b000;
        case (state)
            S_IDLE: begin
                if ((pending != 3'b000) && curr_ok) state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (curr_ok) begin
                    if ((pending & curr_vec) != 3'b000) begin
                        // Already at a requested floor: open the door without driving.
                        tgt_nxt   = curr_vec;
                        clr_mask  = curr_vec;
                        state_nxt = S_ARRIVED;
                    end else if (sel_fwd != 3'b000) begin
                        tgt_nxt   = sel_fwd;
                        state_nxt = S_DRIVE;
                    end else begin
                        dir_nxt   = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                        tgt_nxt   = sel_rev;
                        state_nxt = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                if (bus.idle && (curr_vec == tgt)) begin
                    clr_mask  = tgt;
                    state_nxt = S_ARRIVED;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_FAULT;
                end
            end
            S_ARRIVED: begin
                // Door is open at tgt: presses there are meaningless.
                drop_mask = tgt;
                if (dwell_cnt == DOOR_LAST) state_nxt = S_IDLE;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        pending_nxt = (pending | (rise_vec & ~drop_mask)) & ~clr_mask;
    end

    // Door dwell and drive timeout counters restart on every entry to their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            dwell_cnt <= (state == S_ARRIVED) ? dwell_cnt + DW'(1) : '0;
            to_cnt    <= (state == S_DRIVE)   ? to_cnt + TW'(1)    : '0;
        end
    end

    assign tgt_out     = (state == S_DRIVE) ? tgt : 3'b000;
    assign bus.ground  = tgt_out[0];
    assign bus.first   = tgt_out[1];
    assign bus.second  = tgt_out[2];
    assign bus.pending = pending;
    assign bus.busy    = (state != S_IDLE);
    assign bus.fault   = (state == S_FAULT);

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Directed bench for lift_request_scheduler with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_lift_request_scheduler;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   cycles;
    logic [2:0] seen;

    lift_request_scheduler_if bus ();

    lift_request_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .DOOR_CYCLES(8),
        .DRIVE_TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_curr(input logic [2:0] c);
        bus.curr1 = c[0];
        bus.curr2 = c[1];
        bus.curr3 = c[2];
    endtask

    function automatic logic [31:0] tgt_now();
        return {29'd0, bus.second, bus.first, bus.ground};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        bus.btn_ground = 1'b0;
        bus.btn_first  = 1'b0;
        bus.btn_second = 1'b0;
        bus.idle       = 1'b1;
        set_curr(3'b001);

        repeat (3) tick();
        check("rst_pending", {29'd0, bus.pending}, 32'h0);
        check("rst_target",  tgt_now(), 32'h0);
        check("rst_busy",    {31'd0, bus.busy}, 32'h0);
        check("rst_fault",   {31'd0, bus.fault}, 32'h0);
        reset_n = 1'b1;
        repeat (4) tick();

        // Test 1: car at floor 0, second held for 10 cycles.
        bus.btn_second = 1'b1;
        repeat (5) tick();
        check("t1_pend_cyc5", {29'd0, bus.pending}, 32'h0);
        tick();
        check("t1_pend_cyc6", {29'd0, bus.pending}, 32'h4);
        tick();
        check("t1_select_no_tgt", tgt_now(), 32'h0);
        check("t1_busy", {31'd0, bus.busy}, 32'h1);
        tick();
        check("t1_second", tgt_now(), 32'h4);
        repeat (2) tick();
        bus.btn_second = 1'b0;
        check("t1_second_held", tgt_now(), 32'h4);
        set_curr(3'b100);
        tick();
        check("t1_clear", {29'd0, bus.pending}, 32'h0);
        check("t1_tgt_drop", tgt_now(), 32'h0);
        repeat (7) tick();
        check("t1_dwell_busy", {31'd0, bus.busy}, 32'h1);
        tick();
        check("t1_dwell_done", {31'd0, bus.busy}, 32'h0);

        // Test 2: bouncy first button, then stable; car at floor 2 turns direction down.
        bus.btn_first = 1'b1; tick();
        bus.btn_first = 1'b0; tick();
        bus.btn_first = 1'b1; tick();
        bus.btn_first = 1'b0;
        repeat (6) tick();
        check("t2_bounce_reject", {29'd0, bus.pending}, 32'h0);
        bus.btn_first = 1'b1;
        repeat (5) tick();
        check("t2_stable_cyc5", {29'd0, bus.pending}, 32'h0);
        tick();
        check("t2_stable_cyc6", {29'd0, bus.pending}, 32'h2);
        bus.btn_first = 1'b0;
        repeat (2) tick();
        check("t2_first", tgt_now(), 32'h2);
        set_curr(3'b010);
        tick();
        check("t2_clear", {29'd0, bus.pending}, 32'h0);
        repeat (8) tick();
        check("t2_idle", {31'd0, bus.busy}, 32'h0);

        // Test 6: direction is DOWN now; drive to ground, then reset mid-drive.
        bus.btn_ground = 1'b1;
        repeat (6) tick();
        check("t6_pend", {29'd0, bus.pending}, 32'h1);
        bus.btn_ground = 1'b0;
        repeat (2) tick();
        check("t6_ground", tgt_now(), 32'h1);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_tgt",  tgt_now(), 32'h0);
        check("t6_async_pend", {29'd0, bus.pending}, 32'h0);
        check("t6_async_busy", {31'd0, bus.busy}, 32'h0);
        check("t6_async_fault", {31'd0, bus.fault}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // Test 3: car at floor 1, dir back to UP, ground and second pressed together.
        bus.btn_ground = 1'b1;
        bus.btn_second = 1'b1;
        repeat (6) tick();
        check("t3_both_latch", {29'd0, bus.pending}, 32'h5);
        bus.btn_ground = 1'b0;
        bus.btn_second = 1'b0;
        repeat (2) tick();
        check("t3_up_second", tgt_now(), 32'h4);
        set_curr(3'b100);
        tick();
        check("t3_clear_2", {29'd0, bus.pending}, 32'h1);
        check("t3_tgt_drop", tgt_now(), 32'h0);
        // Press at the open door: accepted only after debounce, still inside dwell.
        bus.btn_second = 1'b1;
        repeat (7) tick();
        check("t3_door_press_drop", {29'd0, bus.pending}, 32'h1);
        bus.btn_second = 1'b0;
        tick();
        check("t3_dwell_end", {31'd0, bus.busy}, 32'h0);
        tick();
        check("t3_select_no_tgt", tgt_now(), 32'h0);
        tick();
        check("t3_down_ground", tgt_now(), 32'h1);
        set_curr(3'b001);
        tick();
        check("t3_clear_0", {29'd0, bus.pending}, 32'h0);
        repeat (8) tick();

        // Test 4: press the floor the car sits at; no target pulse.
        set_curr(3'b010);
        seen = 3'b000;
        bus.btn_first = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= tgt_now()[2:0];
        end
        check("t4_pend", {29'd0, bus.pending}, 32'h2);
        bus.btn_first = 1'b0;
        tick();
        seen |= tgt_now()[2:0];
        check("t4_select_busy", {31'd0, bus.busy}, 32'h1);
        tick();
        seen |= tgt_now()[2:0];
        check("t4_clear", {29'd0, bus.pending}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= tgt_now()[2:0];
        end
        check("t4_no_pulse", {29'd0, seen}, 32'h0);
        check("t4_idle", {31'd0, bus.busy}, 32'h0);

        // Test 5: drive to floor 2, never arrive.
        set_curr(3'b001);
        bus.btn_second = 1'b1;
        repeat (6) tick();
        bus.btn_second = 1'b0;
        repeat (2) tick();
        check("t5_second", tgt_now(), 32'h4);
        cycles = 0;
        while (!bus.fault && cycles < 1100) begin
            tick();
            cycles++;
        end
        check("t5_timeout_cycles", cycles, 32'd1024);
        check("t5_fault", {31'd0, bus.fault}, 32'h1);
        check("t5_tgt_off", tgt_now(), 32'h0);
        bus.btn_first = 1'b1;
        repeat (6) tick();
        bus.btn_first = 1'b0;
        check("t5_pend_in_fault", {29'd0, bus.pending}, 32'h6);
        check("t5_tgt_still_off", tgt_now(), 32'h0);
        check("t5_fault_sticky", {31'd0, bus.fault}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
